// File: rtl/rename_regfile_ckpt_if.sv
// rtl/rename_regfile_ckpt_if.sv - operand, rename, commit and checkpoint bus for rename_regfile_ckpt
interface rename_regfile_ckpt_if #(
    parameter int XLEN          = 32,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int NUM_READ      = 2,
    parameter int NUM_CKPT      = 4
);
    localparam int RWB = ROB_WIDTH_BIT;
    localparam int CW  = $clog2(NUM_CKPT);

    logic [NUM_READ*5-1:0]    ask_reg_id;
    logic [NUM_READ*XLEN-1:0] ret_val;
    logic [NUM_READ-1:0]      ret_dep;
    logic [NUM_READ*RWB-1:0]  ret_rob_id;
    logic [NUM_READ*RWB-1:0]  rob_query_id;
    logic [NUM_READ-1:0]      rob_query_ready;
    logic [NUM_READ*XLEN-1:0] rob_query_val;
    logic [4:0]               new_reg_id;
    logic [RWB-1:0]           new_rob_id;
    logic [4:0]               write_reg_id;
    logic [RWB-1:0]           write_rob_id;
    logic [XLEN-1:0]          write_val;
    logic                     ckpt_save_in;
    logic [CW-1:0]            ckpt_id_out;
    logic                     ckpt_full_out;
    logic                     ckpt_empty_out;
    logic                     ckpt_release_in;
    logic                     ckpt_restore_in;
    logic [CW-1:0]            ckpt_restore_id;

    modport master (
        output ask_reg_id, rob_query_ready, rob_query_val,
        output new_reg_id, new_rob_id, write_reg_id, write_rob_id, write_val,
        output ckpt_save_in, ckpt_release_in, ckpt_restore_in, ckpt_restore_id,
        input  ret_val, ret_dep, ret_rob_id, rob_query_id,
        input  ckpt_id_out, ckpt_full_out, ckpt_empty_out
    );

    modport slave (
        input  ask_reg_id, rob_query_ready, rob_query_val,
        input  new_reg_id, new_rob_id, write_reg_id, write_rob_id, write_val,
        input  ckpt_save_in, ckpt_release_in, ckpt_restore_in, ckpt_restore_id,
        output ret_val, ret_dep, ret_rob_id, rob_query_id,
        output ckpt_id_out, ckpt_full_out, ckpt_empty_out
    );
endinterface

// File: rtl/rename_regfile_ckpt.sv
// rtl/rename_regfile_ckpt.sv - register file and rename table with a ring of tag-table checkpoints
module rename_regfile_ckpt #(
    parameter int XLEN          = 32,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int NUM_READ      = 2,
    parameter int NUM_CKPT      = 4
) (
    input logic clk_in,
    input logic rst_n_in,
    input logic rdy_in,
    input logic flush_in,
    rename_regfile_ckpt_if.slave bus
);
    localparam int RWB = ROB_WIDTH_BIT;
    localparam int CW  = $clog2(NUM_CKPT);

    logic [XLEN-1:0]                     regs [32];
    logic [31:0]                         busy;
    logic [31:0][RWB-1:0]                tags;
    logic [NUM_CKPT-1:0][31:0]           snap_busy;
    logic [NUM_CKPT-1:0][31:0][RWB-1:0]  snap_tag;
    logic [CW-1:0]                       head, tail;
    logic [CW:0]                         count;

    logic          full, empty, commit_en, rename_en, save_en, release_en;
    logic [31:0]   busy_n, restored_busy;
    logic [31:0][RWB-1:0] tags_n;
    logic [CW-1:0] restore_rel;
    logic [CW:0]   restore_cnt;
    logic          restore_valid;
    logic [4:0]    rsel;
    logic          hit, bsy;
    logic [RWB-1:0] tg;

    assign full       = (count == (CW+1)'(NUM_CKPT));
    assign empty      = (count == '0);
    assign commit_en  = (bus.write_reg_id != 5'd0);
    assign rename_en  = (bus.new_reg_id != 5'd0);
    assign save_en    = bus.ckpt_save_in && !full && !bus.ckpt_restore_in;
    // A restore of the head slot keeps that slot, so a same-cycle release must not retire it.
    assign release_en = bus.ckpt_release_in && !empty &&
                        !(bus.ckpt_restore_in && bus.ckpt_restore_id == head);

    assign bus.ckpt_id_out    = tail;
    assign bus.ckpt_full_out  = full;
    assign bus.ckpt_empty_out = empty;

    always_comb begin
        busy_n = busy;
        tags_n = tags;
        if (commit_en && bus.write_reg_id != bus.new_reg_id && tags[bus.write_reg_id] == bus.write_rob_id)
            busy_n[bus.write_reg_id] = 1'b0;
        if (rename_en) begin
            busy_n[bus.new_reg_id] = 1'b1;
            tags_n[bus.new_reg_id] = bus.new_rob_id;
        end
        restored_busy = snap_busy[bus.ckpt_restore_id];
        if (commit_en && snap_tag[bus.ckpt_restore_id][bus.write_reg_id] == bus.write_rob_id)
            restored_busy[bus.write_reg_id] = 1'b0;
        restore_rel   = bus.ckpt_restore_id - head;
        restore_cnt   = {1'b0, restore_rel} + (CW+1)'(1) - (CW+1)'(release_en);
        restore_valid = ({1'b0, restore_rel} < count);
    end

    always_comb begin
        bus.ret_val      = '0;
        bus.ret_dep      = '0;
        bus.ret_rob_id   = '0;
        bus.rob_query_id = '0;
        rsel = '0;
        hit  = 1'b0;
        bsy  = 1'b0;
        tg   = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rsel = bus.ask_reg_id[p*5 +: 5];
            hit  = rename_en && (rsel == bus.new_reg_id);
            bsy  = (busy[rsel] || hit) && (rsel != 5'd0);
            tg   = hit ? bus.new_rob_id : tags[rsel];
            bus.ret_rob_id[p*RWB +: RWB]   = tg;
            bus.rob_query_id[p*RWB +: RWB] = tg;
            bus.ret_dep[p] = bsy && !bus.rob_query_ready[p];
            if (rsel == 5'd0)
                bus.ret_val[p*XLEN +: XLEN] = '0;
            else if (bsy)
                bus.ret_val[p*XLEN +: XLEN] = bus.rob_query_val[p*XLEN +: XLEN];
            else
                bus.ret_val[p*XLEN +: XLEN] = regs[rsel];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            busy      <= '0;
            tags      <= '0;
            snap_busy <= '0;
            snap_tag  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else if (rdy_in) begin
            if (commit_en) regs[bus.write_reg_id] <= bus.write_val;
            if (flush_in) begin
                busy  <= '0;
                tags  <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                // Clearing every slot is safe: invalid slots are fully rewritten before use.
                for (int i = 0; i < NUM_CKPT; i++)
                    if (commit_en && snap_tag[i][bus.write_reg_id] == bus.write_rob_id)
                        snap_busy[i][bus.write_reg_id] <= 1'b0;
                if (bus.ckpt_restore_in) begin
                    busy  <= restored_busy;
                    tags  <= snap_tag[bus.ckpt_restore_id];
                    tail  <= bus.ckpt_restore_id + CW'(1);
                    count <= restore_cnt;
                end else begin
                    busy <= busy_n;
                    tags <= tags_n;
                    if (save_en) begin
                        snap_busy[tail] <= busy_n;
                        snap_tag[tail]  <= tags_n;
                        tail            <= tail + CW'(1);
                    end
                    count <= count + (CW+1)'(save_en) - (CW+1)'(release_en);
                end
                if (release_en) head <= head + CW'(1);
            end
        end
    end

    a_restore_valid: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (rdy_in && !flush_in && bus.ckpt_restore_in) |-> restore_valid);
endmodule
